// File: rtl/alu_pkg.sv
// Shared types and defaults for the ALU datapath blocks.
package alu_pkg;

    // Sequencer states of the bit-serial add/subtract unit.
    typedef enum logic [1:0] {
        SAS_IDLE = 2'd0,
        SAS_RUN  = 2'd1,
        SAS_DONE = 2'd2
    } sas_state_t;

    localparam int SAS_DEFAULT_WIDTH = 32;

endpackage

// File: rtl/full_adder_one_bit.sv
// Single-bit full adder cell: the only arithmetic in the serial unit.
module full_adder_one_bit (
    input  logic inp0,
    input  logic inp1,
    input  logic cin,
    output logic sum,
    output logic cout
);

    // Sum and majority carry of the three input bits.
    always_comb begin
        sum  = inp0 ^ inp1 ^ cin;
        cout = (inp0 & inp1) | (inp0 & cin) | (inp1 & cin);
    end

endmodule

// File: rtl/serial_add_sub_unit.sv
// Bit-serial add/subtract unit: one operand bit pair per cycle through a
// single full adder cell, LSB first, WIDTH RUN cycles per operation.
// Handshake: start is a request taken only in IDLE or DONE (ignored in RUN,
// never queued); done is a one-cycle pulse and result/flags are valid from
// that cycle and held until the next completion; busy is high during RUN.
module serial_add_sub_unit
    import alu_pkg::*;
#(
    parameter  int WIDTH = SAS_DEFAULT_WIDTH,
    localparam int CNT_W = $clog2(WIDTH) + 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             sub,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] result,
    output logic             carry_out,
    output logic             overflow,
    output logic             zero
);

    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WIDTH - 1);

    sas_state_t       state;
    sas_state_t       state_next;
    logic [WIDTH-1:0] a_sh;
    logic [WIDTH-1:0] b_sh;
    // Only WIDTH-1 bits are stored: the newest sum bit comes straight
    // from the cell, so acc_next is the full result on the last RUN cycle.
    logic [WIDTH-2:0] acc;
    logic [WIDTH-1:0] acc_next;
    logic             carry;
    logic [CNT_W-1:0] cnt;
    logic             sum_bit;
    logic             cout_bit;
    logic             accept;
    logic             last_bit;

    full_adder_one_bit u_cell (
        .inp0 (a_sh[0]),
        .inp1 (b_sh[0]),
        .cin  (carry),
        .sum  (sum_bit),
        .cout (cout_bit)
    );

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= SAS_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state logic, request acceptance and status outputs.
    always_comb begin
        state_next = state;
        accept     = 1'b0;
        last_bit   = (cnt == LAST_CNT);
        acc_next   = {sum_bit, acc};
        busy       = (state == SAS_RUN);
        done       = (state == SAS_DONE);
        case (state)
            SAS_IDLE: begin
                if (start) begin
                    accept     = 1'b1;
                    state_next = SAS_RUN;
                end
            end
            SAS_RUN: begin
                if (last_bit) begin
                    state_next = SAS_DONE;
                end
            end
            SAS_DONE: begin
                if (start) begin
                    accept     = 1'b1;
                    state_next = SAS_RUN;
                end else begin
                    state_next = SAS_IDLE;
                end
            end
            default: state_next = SAS_IDLE;
        endcase
    end

    // Operand shift registers, carry flop, accumulator and bit counter.
    // Subtraction is a + ~b + 1: invert b on load and seed the carry with 1.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_sh  <= '0;
            b_sh  <= '0;
            acc   <= '0;
            carry <= 1'b0;
            cnt   <= '0;
        end else if (accept) begin
            a_sh  <= a;
            b_sh  <= sub ? ~b : b;
            carry <= sub;
            cnt   <= '0;
        end else if (state == SAS_RUN) begin
            a_sh  <= a_sh >> 1;
            b_sh  <= b_sh >> 1;
            acc   <= acc_next[WIDTH-1:1];
            carry <= cout_bit;
            cnt   <= cnt + CNT_W'(1);
        end
    end

    // Result and flags load on the last RUN cycle (entry to DONE). At that
    // point carry still holds the carry into the MSB, so overflow needs no
    // separate holding flop.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            result    <= '0;
            carry_out <= 1'b0;
            overflow  <= 1'b0;
            zero      <= 1'b0;
        end else if (state == SAS_RUN && last_bit) begin
            result    <= acc_next;
            carry_out <= cout_bit;
            overflow  <= carry ^ cout_bit;
            zero      <= (acc_next == '0);
        end
    end

endmodule
